alu_operand_stage: RTL and testbench
====================================

Name: alu_operand_stage

Overview:
- Pipeline register stage directly upstream of the ALU. Accepts a decoded instruction from the decode stage and resolves RAW hazards by forwarding from the ALU result and the write-back port.
- Selects register or immediate for operand B.
- Presents registered A, B and ALUControl to the ALU, using a valid/ready handshake with flush.

Parameters:
- XLEN, 32: operand and data width.
- REG_AW, 5: register index width (32 architectural registers, x0 hard-wired to zero).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- InValid  in  1  decode presents a valid instruction.
- InReady  out  1  stage can accept this cycle.
- Rs1Data, Rs2Data  in  XLEN  register-file read data.
- Rs1, Rs2, Rd  in  REG_AW  source and destination indices.
- Imm  in  XLEN  sign-extended immediate.
- UseImm  in  1  when 1, B takes Imm instead of rs2.
- RegWrite  in  1  instruction writes Rd.
- AluOp  in  3  ALU operation code (000 ADD … 111 SLT).
- Flush  in  1  kill held and incoming instruction.
- ExResult  in  XLEN  combinational ALU Result for the instruction currently held.
- WbWrite  in  1  write-back writes this cycle.
- WbRd  in  REG_AW  write-back destination.
- WbData  in  XLEN  write-back data.
- A, B  out  XLEN  registered ALU operands.
- ALUControl  out  3  registered ALU opcode.
- OutValid  out  1  A/B/ALUControl hold a valid instruction.
- OutReady  in  1  ALU/downstream consumes this cycle.
- OutRd  out  REG_AW  held destination index.
- OutRegWrite  out  1  held instruction writes Rd.

Behaviour:
- Reset (rst_n low, asynchronous): OutValid=0, A=0, B=0, ALUControl=000, OutRd=0, OutRegWrite=0. Reset mid-operation discards the held instruction.
- Handshake:
  - InReady = !Flush && (!OutValid || OutReady), purely combinational.
  - Capture occurs on a rising edge when InValid && InReady.
  - Handoff occurs on a rising edge when OutValid && OutReady.
- Latency: one cycle from capture to OutValid.
- Throughput: one instruction per cycle when OutReady stays high.
- Next-state rules:
  - Flush=1: OutValid<=0 and no capture. Data registers are don't-care, but stay held for easier debug.
  - Capture: load all output registers and set OutValid<=1.
  - Handoff without capture: OutValid<=0, data held.
  - Neither: all registers hold. Operands are frozen during stall; WB activity during stall does not alter them.
- Forwarding, evaluated per source operand at capture time, with priority EX > WB > register file:
  - EX hit: OutValid && OutReady && OutRegWrite && OutRd==Rsx && Rsx!=0. The value is ExResult.
  - WB hit: WbWrite && WbRd==Rsx && Rsx!=0. The value is WbData.
  - Otherwise the value is RsxData.
  - Rsx==0 always yields 0, regardless of RsxData or any forwarding match.
- Operand selection:
  - A = forwarded rs1.
  - B = UseImm ? Imm : forwarded rs2.
  - Forwarding for rs2 is ignored when UseImm=1.
- ALUControl <= AluOp unmodified.
- OutRegWrite <= RegWrite && (Rd!=0).
- Simultaneous capture and handoff: the old instruction leaves and the new one loads on the same edge. This is the EX-forward case.
- Load-use hazards are out of scope; decode guarantees them.

Decomposition:
- Shared package alu_pkg:
  - ALU opcode constants (ALU_ADD=000, ALU_SUB=001, ALU_AND=010, ALU_OR=011, ALU_XOR=100, ALU_SLL=101, ALU_SRL=110, ALU_SLT=111).
  - XLEN and REG_AW defaults.
- One sub-module, fwd_mux: combinational 3-way priority select with the x0 rule. It is instantiated twice (rs1 and rs2).

Test Plan:
- Reset then idle: after rst_n release with InValid=0 -> OutValid=0, A=B=0, ALUControl=000; InReady=1.
- Basic capture: Rs1Data=5, Rs2Data=7, AluOp=000, UseImm=0, no hazards -> next cycle OutValid=1, A=5, B=7, ALUControl=000. With UseImm=1 and Imm=0xFFFFFFFC -> B=0xFFFFFFFC.
- EX forward, back-to-back:
  - Held instruction: Rd=3, RegWrite=1, ExResult=0x64, OutReady=1.
  - Incoming: Rs1=3, Rs1Data=0, WbWrite=1, WbRd=3, WbData=0x11.
  - Result: A=0x64 (EX beats WB).
  - Repeat with Rd=0 held -> A=Rs1Data.
- Stall and x0:
  - OutReady=0 with OutValid=1 -> InReady=0, A/B held for 3 cycles despite WbWrite to the same regs.
  - Capture with Rs1=0, Rs1Data=0xDEAD, WbRd=0 -> A=0.
- Flush:
  - Flush=1 with InValid=1 and OutValid=1 -> InReady=0; next cycle OutValid=0 and the incoming instruction is not captured.
  - Asserting rst_n low mid-stall -> OutValid=0 immediately, without a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand stage: opcodes and default widths.
package alu_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side and ALU-side bundle of the operand stage; slave = the stage itself.
interface alu_operand_stage_if import alu_pkg::*; #(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) ();
    logic              InValid;
    logic              InReady;
    logic [XLEN-1:0]   Rs1Data;
    logic [XLEN-1:0]   Rs2Data;
    logic [REG_AW-1:0] Rs1;
    logic [REG_AW-1:0] Rs2;
    logic [REG_AW-1:0] Rd;
    logic [XLEN-1:0]   Imm;
    logic              UseImm;
    logic              RegWrite;
    logic [2:0]        AluOp;
    logic              Flush;
    logic [XLEN-1:0]   ExResult;
    logic              WbWrite;
    logic [REG_AW-1:0] WbRd;
    logic [XLEN-1:0]   WbData;
    logic [XLEN-1:0]   A;
    logic [XLEN-1:0]   B;
    logic [2:0]        ALUControl;
    logic              OutValid;
    logic              OutReady;
    logic [REG_AW-1:0] OutRd;
    logic              OutRegWrite;

    modport master (
        output InValid, Rs1Data, Rs2Data, Rs1, Rs2, Rd, Imm, UseImm, RegWrite,
               AluOp, Flush, ExResult, WbWrite, WbRd, WbData, OutReady,
        input  InReady, A, B, ALUControl, OutValid, OutRd, OutRegWrite
    );

    modport slave (
        input  InValid, Rs1Data, Rs2Data, Rs1, Rs2, Rd, Imm, UseImm, RegWrite,
               AluOp, Flush, ExResult, WbWrite, WbRd, WbData, OutReady,
        output InReady, A, B, ALUControl, OutValid, OutRd, OutRegWrite
    );
endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Per-operand forwarding select: x0 -> 0, then EX result, then WB data, then register file.
module fwd_mux import alu_pkg::*; #(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic [XLEN-1:0]   i_rf_data,
    input  logic              i_ex_fwd,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [XLEN-1:0]   i_ex_data,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [XLEN-1:0]   i_wb_data,
    output logic [XLEN-1:0]   o_data
);
    always_comb begin
        o_data = i_rf_data;
        if (i_rs == '0)
            o_data = '0;
        else if (i_ex_fwd && (i_ex_rd == i_rs))
            o_data = i_ex_data;
        else if (i_wb_we && (i_wb_rd == i_rs))
            o_data = i_wb_data;
    end
endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand stage ahead of the ALU: forwarding, immediate select, valid/ready with flush.
module alu_operand_stage import alu_pkg::*; #(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_operand_stage_if.slave bus
);
    logic              r_valid;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [2:0]        r_ctl;
    logic [REG_AW-1:0] r_rd;
    logic              r_rw;

    logic              w_in_ready;
    logic              w_capture;
    logic              w_handoff;
    logic              w_ex_fwd;
    logic [XLEN-1:0]   w_rs1_val;
    logic [XLEN-1:0]   w_rs2_val;
    logic [XLEN-1:0]   w_b_sel;

    assign w_in_ready = !bus.Flush && (!r_valid || bus.OutReady);
    assign w_capture  = bus.InValid && w_in_ready;
    assign w_handoff  = r_valid && bus.OutReady;
    // ExResult belongs to the held instruction, so it is only usable as it leaves
    assign w_ex_fwd   = w_handoff && r_rw;

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .i_rs      (bus.Rs1),
        .i_rf_data (bus.Rs1Data),
        .i_ex_fwd  (w_ex_fwd),
        .i_ex_rd   (r_rd),
        .i_ex_data (bus.ExResult),
        .i_wb_we   (bus.WbWrite),
        .i_wb_rd   (bus.WbRd),
        .i_wb_data (bus.WbData),
        .o_data    (w_rs1_val)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .i_rs      (bus.Rs2),
        .i_rf_data (bus.Rs2Data),
        .i_ex_fwd  (w_ex_fwd),
        .i_ex_rd   (r_rd),
        .i_ex_data (bus.ExResult),
        .i_wb_we   (bus.WbWrite),
        .i_wb_rd   (bus.WbRd),
        .i_wb_data (bus.WbData),
        .o_data    (w_rs2_val)
    );

    assign w_b_sel = bus.UseImm ? bus.Imm : w_rs2_val;

    // Flush only drops the valid bit; data regs keep their last contents for debug
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_ctl   <= ALU_ADD;
            r_rd    <= '0;
            r_rw    <= 1'b0;
        end else if (bus.Flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_a     <= w_rs1_val;
            r_b     <= w_b_sel;
            r_ctl   <= bus.AluOp;
            r_rd    <= bus.Rd;
            r_rw    <= bus.RegWrite && (bus.Rd != '0);
        end else if (w_handoff) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.InReady     = w_in_ready;
    assign bus.OutValid    = r_valid;
    assign bus.A           = r_a;
    assign bus.B           = r_b;
    assign bus.ALUControl  = r_ctl;
    assign bus.OutRd       = r_rd;
    assign bus.OutRegWrite = r_rw;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: expected operands queued at drive, checked at output.
module tb_alu_operand_stage;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [4:0]  rd;
        logic        rw;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];
    exp_t exp_v;
    exp_t held_e;

    alu_operand_stage_if #(.XLEN(32), .REG_AW(5)) bus ();

    alu_operand_stage #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic exp_t snap();
        return {bus.A, bus.B, bus.ALUControl, bus.OutRd, bus.OutRegWrite};
    endfunction

    task automatic idle();
        bus.InValid  = 0; bus.Rs1 = 0; bus.Rs2 = 0; bus.Rd = 0;
        bus.Rs1Data  = 0; bus.Rs2Data = 0; bus.Imm = 0; bus.UseImm = 0;
        bus.RegWrite = 0; bus.AluOp = 0; bus.Flush = 0; bus.ExResult = 0;
        bus.WbWrite  = 0; bus.WbRd = 0; bus.WbData = 0; bus.OutReady = 1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [31:0] d1,
                         input logic [4:0] rs2, input logic [31:0] d2,
                         input logic [4:0] rd, input logic rw, input logic [2:0] op,
                         input logic useimm, input logic [31:0] imm);
        bus.InValid = 1; bus.Rs1 = rs1; bus.Rs1Data = d1; bus.Rs2 = rs2; bus.Rs2Data = d2;
        bus.Rd = rd; bus.RegWrite = rw; bus.AluOp = op; bus.UseImm = useimm; bus.Imm = imm;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        n_tests++;
        if ({bus.OutValid, bus.InReady} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_hs got valid/ready=%b%b exp=01", bus.OutValid, bus.InReady);
        end
        n_tests++;
        if (snap() !== exp_t'(0)) begin
            n_fail++;
            $display("FAIL reset_regs got=%h exp=0", snap());
        end
    endtask

    task automatic test_basic();
        drive(5'd1, 32'd5, 5'd2, 32'd7, 5'd4, 1, ALU_ADD, 0, 32'd0);
        q.push_back({32'd5, 32'd7, ALU_ADD, 5'd4, 1'b1});
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL basic_rr got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        bus.ExResult = 32'd12;
        drive(5'd1, 32'd5, 5'd2, 32'd7, 5'd5, 1, ALU_SUB, 1, 32'hFFFF_FFFC);
        q.push_back({32'd5, 32'hFFFF_FFFC, ALU_SUB, 5'd5, 1'b1});
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL basic_imm got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        idle();
        @(negedge clk);
        n_tests++;
        if (bus.OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_drain got valid=%b exp=0", bus.OutValid);
        end
    endtask

    task automatic test_ex_forward();
        // rs1=x0 with nonzero read data must still give 0
        drive(5'd0, 32'h1, 5'd0, 32'd0, 5'd3, 1, ALU_ADD, 1, 32'h64);
        q.push_back({32'h0, 32'h64, ALU_ADD, 5'd3, 1'b1});
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL ex_hold got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        bus.ExResult = 32'h64; bus.WbWrite = 1; bus.WbRd = 5'd3; bus.WbData = 32'h11;
        drive(5'd3, 32'd0, 5'd3, 32'h99, 5'd6, 1, ALU_AND, 0, 32'd0);
        q.push_back({32'h64, 32'h64, ALU_AND, 5'd6, 1'b1});
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL ex_beats_wb got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        // held Rd=6: rs1=3 only hits WB, rs2=6 hits EX
        bus.ExResult = 32'h77; bus.WbWrite = 1; bus.WbRd = 5'd3; bus.WbData = 32'h11;
        drive(5'd3, 32'd0, 5'd6, 32'h99, 5'd7, 0, ALU_OR, 0, 32'd0);
        q.push_back({32'h11, 32'h77, ALU_OR, 5'd7, 1'b0});
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL wb_and_ex got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        bus.ExResult = 32'h55; bus.WbWrite = 0;
        drive(5'd7, 32'h70, 5'd7, 32'h71, 5'd0, 1, ALU_XOR, 0, 32'd0);
        q.push_back({32'h70, 32'h71, ALU_XOR, 5'd0, 1'b0});
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL no_fwd_rw0 got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        bus.ExResult = 32'h66;
        drive(5'd3, 32'h33, 5'd0, 32'h44, 5'd9, 1, ALU_SLL, 0, 32'd0);
        q.push_back({32'h33, 32'h0, ALU_SLL, 5'd9, 1'b1});
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL held_rd0 got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2;
        for (int i = 0; i < 4; i++) begin
            d1 = $urandom; d2 = $urandom;
            bus.ExResult = $urandom;
            drive(5'(8 + i), d1, 5'(12 + i), d2, 5'(20 + i), 1, 3'(i), 0, 32'd0);
            q.push_back({d1, d2, 3'(i), 5'(20 + i), 1'b1});
            @(negedge clk);
            exp_v = q.pop_front(); n_tests++;
            if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
                n_fail++;
                $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i, bus.OutValid, snap(), exp_v);
            end
        end
        idle();
        @(negedge clk);
        n_tests++;
        if (bus.OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain got valid=%b exp=0", bus.OutValid);
        end
    endtask

    task automatic test_stall();
        drive(5'd1, 32'hAAAA, 5'd2, 32'hBBBB, 5'd7, 1, ALU_ADD, 0, 32'd0);
        held_e = {32'hAAAA, 32'hBBBB, ALU_ADD, 5'd7, 1'b1};
        q.push_back(held_e);
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL stall_cap got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        bus.OutReady = 0;
        drive(5'd0, 32'hDEAD, 5'd7, 32'd0, 5'd8, 1, ALU_SLT, 0, 32'd0);
        for (int c = 0; c < 3; c++) begin
            bus.WbWrite = 1; bus.WbRd = 5'(1 + (c % 2)); bus.WbData = 32'h1234 + c;
            #1;
            n_tests++;
            if (bus.InReady !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_inready_%0d got=%b exp=0", c, bus.InReady);
            end
            @(negedge clk);
            n_tests++;
            if ({bus.OutValid, snap()} !== {1'b1, held_e}) begin
                n_fail++;
                $display("FAIL stall_hold_%0d got=%b/%h exp=1/%h", c, bus.OutValid, snap(), held_e);
            end
        end
        // release: rs1=x0 with WB to x0 stays 0, rs2=7 forwards from leaving instruction
        bus.OutReady = 1; bus.WbWrite = 1; bus.WbRd = 5'd0; bus.WbData = 32'hBEEF;
        bus.ExResult = 32'h55;
        q.push_back({32'h0, 32'h55, ALU_SLT, 5'd8, 1'b1});
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL x0_and_ex got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        idle();
    endtask

    task automatic test_flush();
        drive(5'd1, 32'd1, 5'd2, 32'd2, 5'd1, 1, ALU_ADD, 0, 32'd0);
        q.push_back({32'd1, 32'd2, ALU_ADD, 5'd1, 1'b1});
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL flush_pre got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        bus.Flush = 1; bus.OutReady = 0;
        drive(5'd4, 32'd4, 5'd5, 32'd5, 5'd10, 1, ALU_SUB, 0, 32'd0);
        #1;
        n_tests++;
        if (bus.InReady !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_inready got=%b exp=0", bus.InReady);
        end
        @(negedge clk);
        n_tests++;
        if (bus.OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_kill got valid=%b exp=0", bus.OutValid);
        end
        idle();
        @(negedge clk);
        n_tests++;
        if (bus.OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_nocap got valid=%b exp=0", bus.OutValid);
        end
    endtask

    task automatic test_reset_mid();
        drive(5'd1, 32'h10, 5'd2, 32'h20, 5'd11, 1, ALU_OR, 0, 32'd0);
        q.push_back({32'h10, 32'h20, ALU_OR, 5'd11, 1'b1});
        @(negedge clk);
        exp_v = q.pop_front(); n_tests++;
        if ({bus.OutValid, snap()} !== {1'b1, exp_v}) begin
            n_fail++;
            $display("FAIL rst_cap got=%b/%h exp=1/%h", bus.OutValid, snap(), exp_v);
        end
        bus.OutReady = 0; bus.InValid = 0;
        @(negedge clk);
        n_tests++;
        if (bus.OutValid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_stall got valid=%b exp=1", bus.OutValid);
        end
        #2 rst_n = 0;
        #1;
        n_tests++;
        if ({bus.OutValid, snap()} !== {1'b0, exp_t'(0)}) begin
            n_fail++;
            $display("FAIL rst_async got=%b/%h exp=0/0", bus.OutValid, snap());
        end
        @(negedge clk);
        rst_n = 1;
        idle();
        @(negedge clk);
        n_tests++;
        if (bus.OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_after got valid=%b exp=0", bus.OutValid);
        end
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_basic();
        test_ex_forward();
        test_back_to_back();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
